// File: rtl/lcd_ctrl.sv
// Purpose : HD44780 4-bit bus sequencer; turns one write strobe into setup/E-pulse/exec-wait timing.
// Latency : E rises in the (SETUP_CYC+1)th cycle after accept; busy lasts 2*(S+H+L)+X (byte) or (S+H+L)+X (nibble).
// Backpr. : busy=1 while a transfer or exec wait runs; wr during busy is dropped and sets sticky ovr.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   wr, wdata, wrs, wnib - write strobe, byte, RS value, nibble-only select
//   busy, ovr           - transfer in progress, sticky dropped-write flag
//   lcd_e, lcd_rw, lcd_rs, lcd_db - LCD pins (all registered, rw tied low)
module lcd_ctrl #(
    parameter int SETUP_CYC     = 2,
    parameter int E_HIGH_CYC    = 8,
    parameter int E_LOW_CYC     = 16,
    parameter int EXEC_CYC      = 1080,
    parameter int LONG_EXEC_CYC = 44000,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [7:0] wdata,
    input  logic       wrs,
    input  logic       wnib,
    output logic       busy,
    output logic       ovr,
    output logic       lcd_e,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic [3:0] lcd_db
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_EHIGH,
        ST_ELOW,
        ST_EXEC
    } state_t;

    // Timer reload values: each state lasts exactly N cycles, so load N-1.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EHIGH_LD = CNT_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] ELOW_LD  = CNT_W'(E_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LEXEC_LD = CNT_W'(LONG_EXEC_CYC - 1);

    state_t           state,     state_nxt;
    logic [CNT_W-1:0] timer,     timer_nxt;
    logic             e_nxt;
    logic             busy_nxt;
    logic             ovr_nxt;
    logic             rs_nxt;
    logic [3:0]       db_nxt;
    logic [3:0]       lo_nib,    lo_nib_nxt;    // low nibble held for the second pulse
    logic             nib_mode,  nib_mode_nxt;
    logic             long_q,    long_nxt;      // clear/home needs the long exec wait
    logic             phase_lo,  phase_lo_nxt;  // 1 once the low nibble is on the bus
    logic             tmr_zero;

    assign tmr_zero = (timer == '0);

    // Write-only interface: R/W is never driven high.
    assign lcd_rw = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            timer    <= '0;
            lcd_e    <= 1'b0;
            busy     <= 1'b0;
            ovr      <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_db   <= 4'h0;
            lo_nib   <= 4'h0;
            nib_mode <= 1'b0;
            long_q   <= 1'b0;
            phase_lo <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            lcd_e    <= e_nxt;
            busy     <= busy_nxt;
            ovr      <= ovr_nxt;
            lcd_rs   <= rs_nxt;
            lcd_db   <= db_nxt;
            lo_nib   <= lo_nib_nxt;
            nib_mode <= nib_mode_nxt;
            long_q   <= long_nxt;
            phase_lo <= phase_lo_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        e_nxt        = lcd_e;
        busy_nxt     = busy;
        ovr_nxt      = ovr;
        rs_nxt       = lcd_rs;
        db_nxt       = lcd_db;
        lo_nib_nxt   = lo_nib;
        nib_mode_nxt = nib_mode;
        long_nxt     = long_q;
        phase_lo_nxt = phase_lo;

        case (state)
            ST_IDLE: begin
                // busy is low only in IDLE, so this is the sole accept point.
                if (wr) begin
                    lo_nib_nxt   = wdata[3:0];
                    nib_mode_nxt = wnib;
                    long_nxt     = !wrs && !wnib && (wdata[7:2] == 6'd0);
                    phase_lo_nxt = 1'b0;
                    ovr_nxt      = 1'b0;
                    rs_nxt       = wrs;
                    db_nxt       = wdata[7:4];
                    busy_nxt     = 1'b1;
                    timer_nxt    = SETUP_LD;
                    state_nxt    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    e_nxt     = 1'b1;
                    timer_nxt = EHIGH_LD;
                    state_nxt = ST_EHIGH;
                end else begin
                    timer_nxt = timer - CNT_W'(1);
                end
            end
            ST_EHIGH: begin
                if (tmr_zero) begin
                    e_nxt     = 1'b0;
                    timer_nxt = ELOW_LD;
                    state_nxt = ST_ELOW;
                end else begin
                    timer_nxt = timer - CNT_W'(1);
                end
            end
            ST_ELOW: begin
                if (tmr_zero) begin
                    if (!nib_mode && !phase_lo) begin
                        // Second half of a full byte; bus changes only here with E low.
                        db_nxt       = lo_nib;
                        phase_lo_nxt = 1'b1;
                        timer_nxt    = SETUP_LD;
                        state_nxt    = ST_SETUP;
                    end else begin
                        timer_nxt = long_q ? LEXEC_LD : EXEC_LD;
                        state_nxt = ST_EXEC;
                    end
                end else begin
                    timer_nxt = timer - CNT_W'(1);
                end
            end
            ST_EXEC: begin
                if (tmr_zero) begin
                    busy_nxt  = 1'b0;
                    state_nxt = ST_IDLE;
                end else begin
                    timer_nxt = timer - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                e_nxt     = 1'b0;
                busy_nxt  = 1'b0;
                timer_nxt = '0;
            end
        endcase

        // A strobe while busy is dropped but remembered.
        if (wr && busy) begin
            ovr_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Purpose : directed bench for lcd_ctrl with default timing parameters.
// Latency : observes outputs on the falling clock edge, one sample per cycle.
// Backpr. : exercises dropped writes, back-to-back accepts and mid-transfer reset.
module tb_lcd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic [7:0] wdata;
    logic       wrs;
    logic       wnib;
    logic       busy;
    logic       ovr;
    logic       lcd_e;
    logic       lcd_rw;
    logic       lcd_rs;
    logic [3:0] lcd_db;

    int checks = 0;
    int errors = 0;

    // Results of the most recent run_xfer call; cycle 1 is the cycle after the accept edge.
    int         r_rise [2];
    int         r_width[2];
    logic [3:0] r_db   [2];
    int         r_npulse;
    int         r_busy_len;
    logic       r_rs;
    logic       r_ovr_c1;
    logic       r_ovr_end;
    bit         r_rw_bad;
    bit         r_db_chg;
    bit         r_timeout;

    lcd_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .wr     (wr),
        .wdata  (wdata),
        .wrs    (wrs),
        .wnib   (wnib),
        .busy   (busy),
        .ovr    (ovr),
        .lcd_e  (lcd_e),
        .lcd_rw (lcd_rw),
        .lcd_rs (lcd_rs),
        .lcd_db (lcd_db)
    );

    always #5 clk = ~clk;

    // Issue one write at the current falling edge and record the pin activity until busy drops
    // (or the cycle limit expires). Between poke_lo and poke_hi wr is driven high with poke_d.
    task automatic run_xfer(input logic [7:0] d, input logic rs_in, input logic nib, input int limit,
                            input int poke_lo, input int poke_hi, input logic [7:0] poke_d,
                            input bit keep_wr);
        int         c;
        int         w;
        bit         done;
        logic       prev_e;
        logic [3:0] prev_db;
        wr = 1'b1; wdata = d; wrs = rs_in; wnib = nib;
        @(posedge clk);
        @(negedge clk);
        r_rise = '{0, 0}; r_width = '{0, 0}; r_db = '{4'h0, 4'h0};
        r_npulse = 0; r_busy_len = 0; r_rs = 1'b0; r_rw_bad = 0; r_db_chg = 0; r_timeout = 0;
        r_ovr_c1 = ovr;
        c = 1; w = 0; done = 0; prev_e = 1'b0; prev_db = lcd_db;
        while (!done) begin
            if (lcd_rw !== 1'b0) r_rw_bad = 1;
            if (lcd_e === 1'b1 && prev_e === 1'b1 && lcd_db !== prev_db) r_db_chg = 1;
            if (lcd_e === 1'b1 && prev_e !== 1'b1) begin
                if (r_npulse < 2) begin
                    r_rise[r_npulse] = c;
                    r_db[r_npulse]   = lcd_db;
                end
                if (r_npulse == 0) r_rs = lcd_rs;
                r_npulse++;
                w = 0;
            end
            if (lcd_e === 1'b1) begin
                w++;
                if (r_npulse >= 1 && r_npulse <= 2) r_width[r_npulse-1] = w;
            end
            if (busy !== 1'b1) begin
                done = 1;
            end else begin
                r_busy_len++;
                if (c >= limit) begin
                    r_timeout = 1;
                    done = 1;
                end else begin
                    prev_e  = lcd_e;
                    prev_db = lcd_db;
                    if (c >= poke_lo && c <= poke_hi) begin
                        wr = 1'b1; wdata = poke_d;
                    end else begin
                        wr = 1'b0;
                    end
                    @(negedge clk);
                    c++;
                end
            end
        end
        r_ovr_end = ovr;
        if (!keep_wr) wr = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; wr = 1'b0; wdata = 8'h00; wrs = 1'b0; wnib = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (ovr !== 1'b0)    begin errors++; $display("FAIL reset_ovr got %b want 0", ovr); end
        checks++; if (lcd_e !== 1'b0)  begin errors++; $display("FAIL reset_e got %b want 0", lcd_e); end
        checks++; if (lcd_rs !== 1'b0) begin errors++; $display("FAIL reset_rs got %b want 0", lcd_rs); end
        checks++; if (lcd_db !== 4'h0) begin errors++; $display("FAIL reset_db got %h want 0", lcd_db); end
        checks++; if (lcd_rw !== 1'b0) begin errors++; $display("FAIL reset_rw got %b want 0", lcd_rw); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_data_byte;
        run_xfer(8'h41, 1'b1, 1'b0, 2000, 0, -1, 8'h00, 0);
        checks++; if (r_rs !== 1'b1)      begin errors++; $display("FAIL byte_rs got %b want 1", r_rs); end
        checks++; if (r_npulse !== 2)     begin errors++; $display("FAIL byte_npulse got %0d want 2", r_npulse); end
        checks++; if (r_rise[0] !== 3)    begin errors++; $display("FAIL byte_e_rise got %0d want 3", r_rise[0]); end
        checks++; if (r_rise[1] !== 29)   begin errors++; $display("FAIL byte_e_rise2 got %0d want 29", r_rise[1]); end
        checks++; if (r_width[0] !== 8 || r_width[1] !== 8)
            begin errors++; $display("FAIL byte_e_width got %0d/%0d want 8/8", r_width[0], r_width[1]); end
        checks++; if (r_db[0] !== 4'h4 || r_db[1] !== 4'h1)
            begin errors++; $display("FAIL byte_db got %h/%h want 4/1", r_db[0], r_db[1]); end
        checks++; if (r_busy_len !== 1132) begin errors++; $display("FAIL byte_busy_len got %0d want 1132", r_busy_len); end
        checks++; if (r_rw_bad !== 0)      begin errors++; $display("FAIL byte_rw got high want low"); end
        checks++; if (r_db_chg !== 0)      begin errors++; $display("FAIL byte_db_stable got change want none"); end
    endtask

    task automatic test_long_exec;
        run_xfer(8'h01, 1'b0, 1'b0, 50000, 0, -1, 8'h00, 0);
        checks++; if (r_db[0] !== 4'h0 || r_db[1] !== 4'h1)
            begin errors++; $display("FAIL clear_db got %h/%h want 0/1", r_db[0], r_db[1]); end
        checks++; if (r_rs !== 1'b0)        begin errors++; $display("FAIL clear_rs got %b want 0", r_rs); end
        checks++; if (r_busy_len !== 44052) begin errors++; $display("FAIL clear_busy_len got %0d want 44052", r_busy_len); end
        // Home: confirm the long wait is selected (busy well past the short-exec end), then abort by reset.
        run_xfer(8'h02, 1'b0, 1'b0, 5000, 0, -1, 8'h00, 0);
        checks++; if (r_timeout !== 1)      begin errors++; $display("FAIL home_long got busy_len %0d want >=5000", r_busy_len); end
        checks++; if (r_db[0] !== 4'h0 || r_db[1] !== 4'h2)
            begin errors++; $display("FAIL home_db got %h/%h want 0/2", r_db[0], r_db[1]); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL home_abort_busy got %b want 0", busy); end
        rst = 1'b0;
        @(negedge clk);
        run_xfer(8'h04, 1'b0, 1'b0, 2000, 0, -1, 8'h00, 0);
        checks++; if (r_busy_len !== 1132) begin errors++; $display("FAIL cmd04_busy_len got %0d want 1132", r_busy_len); end
        checks++; if (r_db[0] !== 4'h0 || r_db[1] !== 4'h4)
            begin errors++; $display("FAIL cmd04_db got %h/%h want 0/4", r_db[0], r_db[1]); end
    endtask

    task automatic test_nibble;
        run_xfer(8'h30, 1'b0, 1'b1, 2000, 0, -1, 8'h00, 0);
        checks++; if (r_npulse !== 1)       begin errors++; $display("FAIL nib_npulse got %0d want 1", r_npulse); end
        checks++; if (r_db[0] !== 4'h3)     begin errors++; $display("FAIL nib_db got %h want 3", r_db[0]); end
        checks++; if (r_width[0] !== 8)     begin errors++; $display("FAIL nib_e_width got %0d want 8", r_width[0]); end
        checks++; if (r_busy_len !== 1106)  begin errors++; $display("FAIL nib_busy_len got %0d want 1106", r_busy_len); end
    endtask

    task automatic test_overrun;
        // Stray write with different data lands in the middle of the first E pulse.
        run_xfer(8'h41, 1'b1, 1'b0, 2000, 5, 5, 8'h99, 0);
        checks++; if (r_ovr_end !== 1'b1)   begin errors++; $display("FAIL ovr_set got %b want 1", r_ovr_end); end
        checks++; if (r_db[0] !== 4'h4 || r_db[1] !== 4'h1)
            begin errors++; $display("FAIL ovr_db got %h/%h want 4/1", r_db[0], r_db[1]); end
        checks++; if (r_rise[0] !== 3 || r_rise[1] !== 29)
            begin errors++; $display("FAIL ovr_rise got %0d/%0d want 3/29", r_rise[0], r_rise[1]); end
        checks++; if (r_busy_len !== 1132)  begin errors++; $display("FAIL ovr_busy_len got %0d want 1132", r_busy_len); end
        run_xfer(8'h04, 1'b0, 1'b0, 2000, 0, -1, 8'h00, 0);
        checks++; if (r_ovr_c1 !== 1'b0)    begin errors++; $display("FAIL ovr_clear got %b want 0", r_ovr_c1); end
    endtask

    task automatic test_reset_mid;
        int k;
        wr = 1'b1; wdata = 8'h41; wrs = 1'b1; wnib = 1'b0;
        @(negedge clk);
        wr = 1'b0;
        k = 1;
        while (k < 5) begin
            @(negedge clk);
            k++;
        end
        checks++; if (lcd_e !== 1'b1) begin errors++; $display("FAIL rstmid_pre_e got %b want 1", lcd_e); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (lcd_e !== 1'b0)  begin errors++; $display("FAIL rstmid_e got %b want 0", lcd_e); end
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (lcd_db !== 4'h0) begin errors++; $display("FAIL rstmid_db got %h want 0", lcd_db); end
        checks++; if (lcd_rs !== 1'b0) begin errors++; $display("FAIL rstmid_rs got %b want 0", lcd_rs); end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        run_xfer(8'h41, 1'b1, 1'b0, 2000, 0, -1, 8'h00, 0);
        checks++; if (r_busy_len !== 1132) begin errors++; $display("FAIL rstmid_after_len got %0d want 1132", r_busy_len); end
        checks++; if (r_db[0] !== 4'h4 || r_db[1] !== 4'h1)
            begin errors++; $display("FAIL rstmid_after_db got %h/%h want 4/1", r_db[0], r_db[1]); end
    endtask

    task automatic test_back_to_back;
        // wr stays high across both transfers; the second byte is presented the cycle busy reads 0.
        run_xfer(8'h48, 1'b1, 1'b0, 2000, 1, 100000, 8'h48, 1);
        checks++; if (r_db[0] !== 4'h4 || r_db[1] !== 4'h8)
            begin errors++; $display("FAIL b2b1_db got %h/%h want 4/8", r_db[0], r_db[1]); end
        checks++; if (r_ovr_end !== 1'b1)  begin errors++; $display("FAIL b2b1_ovr got %b want 1", r_ovr_end); end
        checks++; if (r_db_chg !== 0)      begin errors++; $display("FAIL b2b1_db_stable got change want none"); end
        run_xfer(8'h49, 1'b1, 1'b0, 2000, 1, 100000, 8'h49, 0);
        checks++; if (r_busy_len !== 1132) begin errors++; $display("FAIL b2b2_busy_len got %0d want 1132", r_busy_len); end
        checks++; if (r_rise[0] !== 3)     begin errors++; $display("FAIL b2b2_e_rise got %0d want 3", r_rise[0]); end
        checks++; if (r_db[0] !== 4'h4 || r_db[1] !== 4'h9)
            begin errors++; $display("FAIL b2b2_db got %h/%h want 4/9", r_db[0], r_db[1]); end
        checks++; if (r_ovr_c1 !== 1'b0)   begin errors++; $display("FAIL b2b2_ovr_clear got %b want 0", r_ovr_c1); end
        checks++; if (r_ovr_end !== 1'b1)  begin errors++; $display("FAIL b2b2_ovr got %b want 1", r_ovr_end); end
        checks++; if (r_db_chg !== 0)      begin errors++; $display("FAIL b2b2_db_stable got change want none"); end
        @(negedge clk);
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL b2b_idle got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_data_byte();
        test_long_exec();
        test_nibble();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
